// File: rtl/core_seq.sv
// Fetch/execute sequencer for a single-issue RV32I core: fetch handshake, commit gating, trap halts.
// Optional watchdog halt is built when CORE_SEQ_WATCHDOG_EN is defined.
module core_seq #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          WDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        illegal,
    input  logic        exec_done,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        commit,
    output logic        halted,
    output logic [1:0]  halt_code,
    output logic [31:0] retired,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] halt_code_nxt;
    logic       wdog_expire;

`ifdef CORE_SEQ_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_expire = (state != HALT) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (commit) begin
            wdog_cnt <= '0;
        end else if (state != HALT) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        halt_code_nxt = halt_code;
        commit        = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack) state_nxt = EXEC;
            end
            EXEC: begin
                // ebreak outranks the illegal flag; a misaligned target is reported as illegal
                if (inst == EBREAK) begin
                    state_nxt     = HALT;
                    halt_code_nxt = 2'b01;
                end else if (illegal) begin
                    state_nxt     = HALT;
                    halt_code_nxt = 2'b10;
                end else if (exec_done) begin
                    if (next_pc[1:0] == 2'b00) begin
                        commit    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt     = HALT;
                        halt_code_nxt = 2'b10;
                    end
                end
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
        // A retiring instruction beats watchdog expiry; a real trap keeps its own code
        if (wdog_expire && !commit && state_nxt != HALT) begin
            state_nxt     = HALT;
            halt_code_nxt = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            inst      <= '0;
            retired   <= '0;
            halt_code <= 2'b00;
        end else begin
            state     <= state_nxt;
            halt_code <= halt_code_nxt;
            if (state == FETCH && imem_ack) inst <= imem_rdata;
            if (commit) begin
                pc      <= next_pc;
                retired <= retired + 32'd1;
            end
        end
    end

    assign imem_req   = (state == FETCH) && !rst;
    assign imem_addr  = pc;
    assign inst_valid = (state == EXEC);
    assign halted     = (state == HALT);
    assign dbg_state  = state;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: drives fetch/exec handshakes, tracks a PC/retire model and an expected-PC queue.
module tb_core_seq;

    localparam logic [31:0] RPC    = 32'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        illegal;
    logic        exec_done;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        commit;
    logic        halted;
    logic [1:0]  halt_code;
    logic [31:0] retired;
    logic [1:0]  dbg_state;

    core_seq #(.RESET_PC(RPC), .WDOG_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .illegal(illegal),
        .exec_done(exec_done), .next_pc(next_pc), .pc(pc), .commit(commit),
        .halted(halted), .halt_code(halt_code), .retired(retired), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] cur_inst;

    task automatic do_reset;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; illegal = 1'b0; exec_done = 1'b0; next_pc = '0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
        vectors++; if (pc !== RPC) begin miscompares++; $display("FAIL rst_pc: got %h want %h", pc, RPC); end
        vectors++; if ({halted, halt_code, commit, inst_valid} !== 5'b0) begin miscompares++; $display("FAIL rst_flags: got %b want 00000", {halted, halt_code, commit, inst_valid}); end
        vectors++; if ({retired, inst} !== 64'h0) begin miscompares++; $display("FAIL rst_cnt_inst: got %h want 0", {retired, inst}); end
        rst = 1'b0;
        #1;
        vectors++; if ({imem_req, imem_addr} !== {1'b1, RPC}) begin miscompares++; $display("FAIL rst_fetch: got %h want %h", {imem_req, imem_addr}, {1'b1, RPC}); end
        m_pc = RPC; m_ret = '0; exp_q.delete();
    endtask

    // driver: hold the fetch for waits cycles, then ack with word
    task automatic fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            vectors++; if ({imem_req, imem_addr} !== {1'b1, m_pc}) begin miscompares++; $display("FAIL fetch_hold: got %h want %h", {imem_req, imem_addr}, {1'b1, m_pc}); end
            @(negedge clk);
        end
        imem_ack = 1'b1; imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        cur_inst = word;
        vectors++; if ({inst_valid, inst} !== {1'b1, word}) begin miscompares++; $display("FAIL fetch_latch: got %h want %h", {inst_valid, inst}, {1'b1, word}); end
    endtask

    // driver: stall exec for waits cycles (with stray acks), then finish with npc
    task automatic exec_commit(input logic [31:0] npc, input int waits);
        logic [31:0] exp_pc;
        exp_q.push_back(npc);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b1; imem_rdata = $urandom;
            #1;
            vectors++; if (commit !== 1'b0) begin miscompares++; $display("FAIL stall_commit: got %b want 0", commit); end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        vectors++; if ({inst_valid, inst} !== {1'b1, cur_inst}) begin miscompares++; $display("FAIL stall_inst: got %h want %h", {inst_valid, inst}, {1'b1, cur_inst}); end
        exec_done = 1'b1; next_pc = npc;
        #1;
        vectors++; if (commit !== 1'b1) begin miscompares++; $display("FAIL commit_pulse: got %b want 1", commit); end
        @(negedge clk);
        exec_done = 1'b0;
        exp_pc = exp_q.pop_front();
        m_pc = exp_pc; m_ret = m_ret + 32'd1;
        vectors++; if (pc !== m_pc) begin miscompares++; $display("FAIL commit_pc: got %h want %h", pc, m_pc); end
        vectors++; if (retired !== m_ret) begin miscompares++; $display("FAIL commit_retired: got %0d want %0d", retired, m_ret); end
        vectors++; if ({commit, imem_req, halted} !== 3'b010) begin miscompares++; $display("FAIL commit_after: got %b want 010", {commit, imem_req, halted}); end
    endtask

    task automatic test_reset;
        do_reset();
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_basic;
        do_reset();
        fetch(NOP, 0);
        exec_commit(32'h8000_0004, 0);
        vectors++; if ({pc, retired} !== {32'h8000_0004, 32'd1}) begin miscompares++; $display("FAIL basic: got %h want %h", {pc, retired}, {32'h8000_0004, 32'd1}); end
    endtask

    task automatic test_ebreak;
        fetch(NOP, 1);
        exec_commit(32'h8000_0008, 2);
        fetch(EBREAK, $urandom_range(0, 2));
        exec_done = 1'b1; next_pc = 32'h8000_000C;
        #1;
        vectors++; if ({commit, halted} !== 2'b00) begin miscompares++; $display("FAIL ebreak_cycle: got %b want 00", {commit, halted}); end
        @(negedge clk);
        vectors++; if ({halted, halt_code, imem_req, inst_valid} !== 5'b10100) begin miscompares++; $display("FAIL ebreak_halt: got %b want 10100", {halted, halt_code, imem_req, inst_valid}); end
        vectors++; if ({pc, retired} !== {32'h8000_0008, 32'd2}) begin miscompares++; $display("FAIL ebreak_frozen: got %h want %h", {pc, retired}, {32'h8000_0008, 32'd2}); end
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1; imem_rdata = $urandom; illegal = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++; if ({halted, halt_code, imem_req, commit, pc} !== {1'b1, 2'b01, 1'b0, 1'b0, 32'h8000_0008}) begin miscompares++; $display("FAIL halt_sticky: got %h", {halted, halt_code, imem_req, commit, pc}); end
        end
        imem_ack = 1'b0; exec_done = 1'b0; illegal = 1'b0;
    endtask

    task automatic test_illegal;
        do_reset();
        fetch(32'hFFFF_FFFF, 0);
        illegal = 1'b1; exec_done = 1'b1; next_pc = RPC + 32'd4;
        #1;
        vectors++; if (commit !== 1'b0) begin miscompares++; $display("FAIL illegal_commit: got %b want 0", commit); end
        @(negedge clk);
        illegal = 1'b0; exec_done = 1'b0;
        vectors++; if ({halted, halt_code, pc, retired} !== {1'b1, 2'b10, RPC, 32'd0}) begin miscompares++; $display("FAIL illegal_halt: got %h", {halted, halt_code, pc, retired}); end
        do_reset();
        fetch(EBREAK, 0);
        illegal = 1'b1;
        @(negedge clk);
        illegal = 1'b0;
        vectors++; if ({halted, halt_code} !== 3'b101) begin miscompares++; $display("FAIL ebreak_prio: got %b want 101", {halted, halt_code}); end
    endtask

    task automatic test_misaligned;
        do_reset();
        fetch(NOP, 0);
        exec_commit(RPC + 32'd4, 1);
        fetch(NOP, 0);
        exec_done = 1'b1; next_pc = 32'h8000_0006;
        #1;
        vectors++; if (commit !== 1'b0) begin miscompares++; $display("FAIL misalign_commit: got %b want 0", commit); end
        @(negedge clk);
        exec_done = 1'b0;
        vectors++; if ({halted, halt_code, pc, retired} !== {1'b1, 2'b10, 32'h8000_0004, 32'd1}) begin miscompares++; $display("FAIL misalign_halt: got %h", {halted, halt_code, pc, retired}); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] word;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            word = $urandom;
            if (word == EBREAK) word = NOP;
            fetch(word, $urandom_range(0, 3));
            exec_commit(m_pc + 32'd4 * 32'($urandom_range(1, 8)), $urandom_range(0, 3));
        end
        vectors++; if (retired !== 32'd10) begin miscompares++; $display("FAIL b2b_retired: got %0d want 10", retired); end
    endtask

    task automatic test_rst_in_exec;
        do_reset();
        fetch(NOP, 0);
        exec_commit(RPC + 32'd4, 0);
        fetch(NOP, 0);
        exec_done = 1'b1; next_pc = RPC + 32'd8;
        #1;
        rst = 1'b1;
        #1;
        vectors++; if ({commit, imem_req, inst_valid} !== 3'b000) begin miscompares++; $display("FAIL rst_exec_flags: got %b want 000", {commit, imem_req, inst_valid}); end
        vectors++; if ({pc, retired, inst} !== {RPC, 32'd0, 32'd0}) begin miscompares++; $display("FAIL rst_exec_state: got %h", {pc, retired, inst}); end
        @(negedge clk);
        rst = 1'b0; exec_done = 1'b0;
        #1;
        vectors++; if ({imem_req, imem_addr, retired, halted} !== {1'b1, RPC, 32'd0, 1'b0}) begin miscompares++; $display("FAIL rst_exec_restart: got %h", {imem_req, imem_addr, retired, halted}); end
    endtask

    task automatic test_watchdog;
        do_reset();
`ifdef CORE_SEQ_WATCHDOG_EN
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            vectors++; if (halted !== (i == 16)) begin miscompares++; $display("FAIL wdog_fetch cycle %0d: got %b want %b", i, halted, (i == 16)); end
        end
        vectors++; if (halt_code !== 2'b11) begin miscompares++; $display("FAIL wdog_code: got %b want 11", halt_code); end
        do_reset();
        fetch(NOP, 0);
        exec_commit(RPC + 32'd4, 14);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            vectors++; if (halted !== (i == 16)) begin miscompares++; $display("FAIL wdog_after_commit cycle %0d: got %b want %b", i, halted, (i == 16)); end
        end
`else
        repeat (1000) @(negedge clk);
        vectors++; if ({imem_req, halted, halt_code, dbg_state} !== {1'b1, 1'b0, 2'b00, 2'd0}) begin miscompares++; $display("FAIL no_wdog: got %b want 100000", {imem_req, halted, halt_code, dbg_state}); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ebreak();
        test_illegal();
        test_misaligned();
        test_back_to_back();
        test_rst_in_exec();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, is the PC value loaded on reset.
REQ-002 Parameter WDOG_CYCLES, default 1024, is the maximum cycles without a commit before a watchdog halt.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request (level).
REQ-006 imem_addr  output  32  fetch address; equals pc.
REQ-007 imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 inst  output  32  latched instruction under execution.
REQ-010 inst_valid  output  1  high while in EXEC.
REQ-011 illegal  input  1  decode flag: inst is not a legal RV32I encoding.
REQ-012 exec_done  input  1  datapath has finished inst and next_pc is valid.
REQ-013 next_pc  input  32  datapath-computed successor PC.
REQ-014 pc  output  32  architectural PC.
REQ-015 commit  output  1  one-cycle pulse gating register-file/memory writes for the retiring instruction.
REQ-016 halted  output  1  core stopped.
REQ-017 halt_code  output  2  00 running, 01 good trap (ebreak), 10 illegal/misaligned, 11 watchdog.
REQ-018 retired  output  32  count of committed instructions.

Function
REQ-019 The FSM SHALL have states FETCH, EXEC and HALT, and SHALL leave reset in FETCH.
REQ-020 In FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack; on imem_ack, inst<=imem_rdata and the FSM moves to EXEC (1-cycle minimum fetch).
REQ-021 imem_ack outside FETCH SHALL be ignored.
REQ-022 In EXEC with inst==32'h0010_0073 (ebreak): go to HALT with halt_code=01; no commit; pc unchanged; retired unchanged.
REQ-023 In EXEC, not ebreak, illegal=1: go to HALT with halt_code=10; no commit; ebreak has priority over illegal.
REQ-024 In EXEC, legal, exec_done=1, next_pc[1:0]==0: commit=1 that cycle (combinational), pc<=next_pc, retired<=retired+1, go to FETCH.
REQ-025 In EXEC, legal, exec_done=1, next_pc[1:0]!=0: go to HALT with halt_code=10; no commit; pc unchanged.
REQ-026 In EXEC without exec_done and without a trap, the FSM SHALL stay in EXEC.
REQ-027 HALT SHALL be sticky until rst: imem_req=0, commit=0, halted=1, and pc, retired and halt_code frozen.
REQ-028 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 A trap decision SHALL take effect on the EXEC cycle it is detected; halted asserts the following cycle.

Reset
REQ-030 On rst, asynchronously: pc=RESET_PC, state=FETCH, inst=0, retired=0, halt_code=00, halted=0, imem_req=0 while rst is high, commit=0, watchdog counter=0.
REQ-031 rst asserted mid-fetch or mid-exec SHALL abort the operation with no commit; fetch restarts at RESET_PC after deassertion.

Configuration
REQ-032 With CORE_SEQ_WATCHDOG_EN defined: a counter increments every cycle in FETCH or EXEC, clears on commit, and on reaching WDOG_CYCLES forces HALT with halt_code=11.
REQ-033 If commit and watchdog expiry coincide, commit SHALL win and the counter SHALL clear.
REQ-034 Without CORE_SEQ_WATCHDOG_EN: no counter is built and halt_code=11 is never produced.

Verification
REQ-035 Reset, then imem_ack with rdata=32'h0000_0013, then exec_done with next_pc=32'h8000_0004 -> exactly one commit pulse, pc=32'h8000_0004, retired=1.
REQ-036 Fetch returns 32'h0010_0073 at pc 32'h8000_0008 -> halt_code=01, halted=1 next cycle, pc stays 32'h8000_0008, no commit, imem_req=0 thereafter.
REQ-037 Fetch returns 32'hFFFF_FFFF with illegal=1 -> halt_code=10; the same word with ebreak encoding and illegal=1 -> halt_code=01.
REQ-038 exec_done with next_pc=32'h8000_0006 -> halt_code=10, no commit, pc unchanged.
REQ-039 With CORE_SEQ_WATCHDOG_EN and WDOG_CYCLES=16, imem_ack held low -> halt_code=11 after 16 cycles in FETCH; without the macro -> still in FETCH after 1000 cycles.
REQ-040 rst pulsed while in EXEC with exec_done=1 in the same cycle -> no commit, pc=RESET_PC, retired=0, imem_req reasserts after rst falls.
